spi_accel_responder: RTL

- Synthesizable SPI mode-0 slave modelling the accelerometer side of the link: the responder to the on-board SPI master/interface pair.
- Implements the accelerometer command set over a small register file:
  - 0x0A = register write; 0x0B = register read; address auto-increments through a burst.
- Used as a loopback target in FPGA builds and as the bench-side device model in system simulation.
- Axis samples are fed from fabric.

---
 rtl/spi_accel_pkg.sv | 31 +++
 rtl/spi_sync_edge.sv | 19 +
 rtl/spi_accel_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/spi_accel_pkg.sv
// Shared command codes, register map and FSM state type for the SPI accelerometer responder.
package spi_accel_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] REG_DEVID_AD  = 8'h00;
  localparam logic [7:0] REG_DEVID_MST = 8'h01;
  localparam logic [7:0] REG_PARTID    = 8'h02;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] REG_XDATA_H   = 8'h0F;
  localparam logic [7:0] REG_YDATA_L   = 8'h10;
  localparam logic [7:0] REG_YDATA_H   = 8'h11;
  localparam logic [7:0] REG_ZDATA_L   = 8'h12;
  localparam logic [7:0] REG_ZDATA_H   = 8'h13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

  // ID bytes and live axis samples cannot be overwritten over SPI
  function automatic logic is_read_only(input logic [7:0] a);
    return (a <= REG_PARTID) || ((a >= REG_XDATA_L) && (a <= REG_ZDATA_H));
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge (
  input  logic clk,
  input  logic d,
  output logic rise,
  output logic fall
);

  // Deliberately unreset: a chip_select held low across rst must not look like a fresh falling edge
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    sh <= {sh[1:0], d};
  end

  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave presenting the accelerometer register file; axis samples arrive from fabric.
//  state  | meaning
//  IDLE   | deselected, sample registers track fabric
//  CMD    | shifting in command byte
//  ADDR   | shifting in start address
//  READ   | streaming reg[addr] out on miso, auto-increment
//  WRITE  | shifting in data bytes, auto-increment
//  IGNORE | unknown command, miso held low until deselect
module spi_accel_responder
  import spi_accel_pkg::*;
#(
  parameter int          NUM_REGS  = 64,
  parameter int          ADDR_W    = $clog2(NUM_REGS),
  parameter logic [7:0]  DEVID_AD  = 8'hAD,
  parameter logic [7:0]  DEVID_MST = 8'h1D,
  parameter logic [7:0]  PARTID    = 8'hF2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              chip_select,
  output logic              miso,
  output logic              miso_oe,
  input  logic              sample_valid,
  input  logic [15:0]       x_sample,
  input  logic [15:0]       y_sample,
  input  logic [15:0]       z_sample,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  state_t state, state_next;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_sync;
  logic mosi_s;

  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [6:0]        tx_shift;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic              wr_mode, rd_first;
  logic [7:0]        regs [NUM_REGS];

  logic [15:0] shadow_x, shadow_y, shadow_z, load_x, load_y, load_z;
  logic        pending, sample_load;

  logic [7:0] rx_byte, start_byte, next_byte;
  logic       active, rx_done, wr_en;

  spi_sync_edge u_sync_sclk (.clk(clk), .d(sclk),        .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_sync_cs   (.clk(clk), .d(chip_select), .rise(cs_rise),   .fall(cs_fall));

  always_ff @(posedge clk) begin
    mosi_sync <= {mosi_sync[0], mosi};
  end
  assign mosi_s = mosi_sync[1];

  assign rx_byte    = {rx_shift, mosi_s};
  assign addr_inc   = addr + ADDR_W'(1);
  assign start_byte = regs[rx_byte[ADDR_W-1:0]];
  assign next_byte  = regs[addr_inc];
  assign active     = (state != ST_IDLE) && !cs_rise;
  assign rx_done    = active && sclk_rise && (bit_cnt == 3'd7);
  assign wr_en      = (state == ST_WRITE) && rx_done && !is_read_only(8'(addr));
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cs_fall) state_next = ST_CMD;
      ST_CMD:  if (rx_done) state_next = ((rx_byte == CMD_READ) || (rx_byte == CMD_WRITE)) ? ST_ADDR : ST_IGNORE;
      ST_ADDR: if (rx_done) state_next = wr_mode ? ST_WRITE : ST_READ;
      default: ;
    endcase
    if ((state != ST_IDLE) && cs_rise) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      addr      <= '0;
      wr_mode   <= 1'b0;
      rd_first  <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (state == ST_IDLE) begin
        if (cs_fall) begin
          bit_cnt <= '0;
          miso_oe <= 1'b1;
          miso    <= 1'b0;
        end
      end else if (cs_rise) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        case (state)
          ST_CMD: if (rx_done) wr_mode <= (rx_byte == CMD_WRITE);
          ST_ADDR: if (rx_done) begin
            addr <= rx_byte[ADDR_W-1:0];
            if (!wr_mode) begin
              miso     <= start_byte[7];
              tx_shift <= start_byte[6:0];
              rd_first <= 1'b1;
            end
          end
          // The address byte's own trailing falling edge lands here and must not shift
          ST_READ: if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              miso     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end else if (rd_first) begin
              rd_first <= 1'b0;
            end else begin
              addr     <= addr_inc;
              miso     <= next_byte[7];
              tx_shift <= next_byte[6:0];
            end
          end
          ST_WRITE: if (rx_done) begin
            addr <= addr_inc;
            if (wr_en) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
              wr_data   <= rx_byte;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Samples arriving mid-transaction are parked so a burst read stays coherent
  assign sample_load = (state == ST_IDLE) && (sample_valid || pending);
  assign load_x = sample_valid ? x_sample : shadow_x;
  assign load_y = sample_valid ? y_sample : shadow_y;
  assign load_z = sample_valid ? z_sample : shadow_z;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[ADDR_W'(REG_DEVID_AD)]  <= DEVID_AD;
      regs[ADDR_W'(REG_DEVID_MST)] <= DEVID_MST;
      regs[ADDR_W'(REG_PARTID)]    <= PARTID;
      shadow_x <= '0;
      shadow_y <= '0;
      shadow_z <= '0;
      pending  <= 1'b0;
    end else begin
      if (wr_en) regs[addr] <= rx_byte;
      if (sample_load) begin
        regs[ADDR_W'(REG_XDATA_L)] <= load_x[7:0];
        regs[ADDR_W'(REG_XDATA_H)] <= load_x[15:8];
        regs[ADDR_W'(REG_YDATA_L)] <= load_y[7:0];
        regs[ADDR_W'(REG_YDATA_H)] <= load_y[15:8];
        regs[ADDR_W'(REG_ZDATA_L)] <= load_z[7:0];
        regs[ADDR_W'(REG_ZDATA_H)] <= load_z[15:8];
        pending <= 1'b0;
      end else if ((state != ST_IDLE) && sample_valid) begin
        shadow_x <= x_sample;
        shadow_y <= y_sample;
        shadow_z <= z_sample;
        pending  <= 1'b1;
      end
    end
  end

endmodule
